cpu86_io_responder: RTL and testbench

Synthesizable I/O-port responder that terminates the cpu86 `m_axis_io_req` / `s_axis_io_res` channel. It replaces the behavioural I/O model with real RTL. It decodes IN/OUT requests against a bank of 16-bit port registers mapped at a configurable base port. For every IN it returns one 16-bit read response. It sits between the cpu86 core and on-board peripherals, which see the register bank as a flat output bus.

---
 rtl/cpu86_io_pkg.sv | 26 ++
 rtl/cpu86_io_regfile.sv | 41 ++++
 rtl/cpu86_io_responder.sv | 85 ++++++++
 tb/tb_cpu86_io_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu86_io_pkg.sv
// Shared definitions for the cpu86 I/O request/response channel.
// Used by the initiator in the core and by the responder.
package cpu86_io_pkg;

  typedef struct packed {
    logic        wr;
    logic        word;
    logic [5:0]  rsvd;
    logic [15:0] port;
    logic [15:0] wdata;
  } io_req_t;

  localparam int IO_REQ_W     = $bits(io_req_t);
  localparam int IO_WR_BIT    = 39;
  localparam int IO_WORD_BIT  = 38;
  localparam int IO_RSVD_MSB  = 37;
  localparam int IO_RSVD_LSB  = 32;
  localparam int IO_PORT_MSB  = 31;
  localparam int IO_PORT_LSB  = 16;
  localparam int IO_WDATA_MSB = 15;
  localparam int IO_WDATA_LSB = 0;

  localparam logic [15:0] IO_MISS_WORD = 16'hFFFF;
  localparam logic [15:0] IO_MISS_BYTE = 16'h00FF;

endpackage

// File: rtl/cpu86_io_regfile.sv
// Bank of 16-bit I/O registers with per-byte write enables,
// a combinational read mux and a flat view of all registers.
module cpu86_io_regfile #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [1:0]             wr_be,
  input  logic [15:0]            wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [15:0]            rd_data,
  output logic [16*NUM_REGS-1:0] regs_tdata
);

  logic [NUM_REGS-1:0][15:0] regs;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [15:0] q;
    logic        sel;

    assign sel = wr_en && (wr_idx == IDX_W'(g));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q <= '0;
      end else if (sel) begin
        if (wr_be[0]) q[7:0]  <= wr_data[7:0];
        if (wr_be[1]) q[15:8] <= wr_data[15:8];
      end
    end

    assign regs[g] = q;
  end

  assign rd_data    = regs[rd_idx];
  assign regs_tdata = regs;

endmodule

// File: rtl/cpu86_io_responder.sv
// Terminates the cpu86 I/O channel: decodes IN/OUT against a register
// window and returns one registered read response per IN.
module cpu86_io_responder
  import cpu86_io_pkg::*;
#(
  parameter logic [15:0] BASE_PORT = 16'h0080,
  parameter int          NUM_REGS  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_axis_req_tvalid,
  output logic                   s_axis_req_tready,
  input  logic [IO_REQ_W-1:0]    s_axis_req_tdata,
  output logic                   m_axis_res_tvalid,
  input  logic                   m_axis_res_tready,
  output logic [15:0]            m_axis_res_tdata,
  output logic [16*NUM_REGS-1:0] regs_tdata
);

  localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [16:0] WIN_LO = {1'b0, BASE_PORT};
  localparam logic [16:0] WIN_HI = {1'b0, BASE_PORT} + 17'(2 * NUM_REGS);

  logic        wr, word, lane, hit, accept;
  logic [15:0] port, wdata, offset, rd_data, res_data;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [IDX_W-1:0] idx;
  logic        rsvd_unused;

  assign wr    = s_axis_req_tdata[IO_WR_BIT];
  assign word  = s_axis_req_tdata[IO_WORD_BIT];
  assign port  = s_axis_req_tdata[IO_PORT_MSB:IO_PORT_LSB];
  assign wdata = s_axis_req_tdata[IO_WDATA_MSB:IO_WDATA_LSB];

  // 17-bit compare so a window ending at 16'hFFFF does not wrap
  assign hit    = ({1'b0, port} >= WIN_LO) && ({1'b0, port} < WIN_HI);
  assign offset = port - BASE_PORT;
  assign idx    = offset[IDX_W:1];
  assign lane   = offset[0];

  assign rsvd_unused = ^{s_axis_req_tdata[IO_RSVD_MSB:IO_RSVD_LSB], offset};

  // The slot can take a new request whenever it is empty or draining this cycle.
  assign s_axis_req_tready = !m_axis_res_tvalid || m_axis_res_tready;
  assign accept            = s_axis_req_tvalid && s_axis_req_tready;

  // Byte writes replicate the byte so either lane enable picks it up.
  assign wr_be   = word ? 2'b11 : (lane ? 2'b10 : 2'b01);
  assign wr_data = word ? wdata : {wdata[7:0], wdata[7:0]};

  cpu86_io_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (accept && wr && hit),
    .wr_idx     (idx),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .rd_idx     (idx),
    .rd_data    (rd_data),
    .regs_tdata (regs_tdata)
  );

  always_comb begin
    res_data = rd_data;
    if (!hit)       res_data = word ? IO_MISS_WORD : IO_MISS_BYTE;
    else if (!word) res_data = {8'h00, lane ? rd_data[15:8] : rd_data[7:0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_res_tvalid <= 1'b0;
      m_axis_res_tdata  <= '0;
    end else if (accept && !wr) begin
      m_axis_res_tvalid <= 1'b1;
      m_axis_res_tdata  <= res_data;
    end else if (m_axis_res_tready) begin
      m_axis_res_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu86_io_responder.sv
// Self-checking bench: directed vector table, backpressure and reset
// sequences, then randomized traffic against a behavioural port model.
module tb_cpu86_io_responder;
  import cpu86_io_pkg::*;

  localparam logic [15:0] BASE = 16'h0080;
  localparam int          NR   = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              s_valid, s_ready;
  logic [39:0]       s_data;
  logic              r_valid, r_ready;
  logic [15:0]       r_data;
  logic [16*NR-1:0]  regs;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [NR];

  always #5 clk = ~clk;

  cpu86_io_responder #(.BASE_PORT(BASE), .NUM_REGS(NR)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_axis_req_tvalid (s_valid),
    .s_axis_req_tready (s_ready),
    .s_axis_req_tdata  (s_data),
    .m_axis_res_tvalid (r_valid),
    .m_axis_res_tready (r_ready),
    .m_axis_res_tdata  (r_data),
    .regs_tdata        (regs)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input logic wr, input logic word,
                                     input logic [15:0] port, input logic [15:0] wd);
    io_req_t r;
    r.wr = wr; r.word = word; r.rsvd = 6'($urandom); r.port = port; r.wdata = wd;
    return r;
  endfunction

  // Behavioural port model: returns the IN response, applies OUT writes.
  function automatic logic [15:0] model_access(input logic wr, input logic word,
                                               input logic [15:0] port, input logic [15:0] wd);
    int  off = int'(port) - int'(BASE);
    bit  h   = (off >= 0) && (off < 2 * NR);
    int  i   = h ? off / 2 : 0;
    bit  hi  = (off % 2) == 1;
    if (wr) begin
      if (h) begin
        if (word)    mdl[i] = wd;
        else if (hi) mdl[i][15:8] = wd[7:0];
        else         mdl[i][7:0]  = wd[7:0];
      end
      return 16'h0000;
    end
    if (!h) return word ? 16'hFFFF : 16'h00FF;
    if (word) return mdl[i];
    return hi ? {8'h00, mdl[i][15:8]} : {8'h00, mdl[i][7:0]};
  endfunction

  function automatic logic [16*NR-1:0] model_flat();
    logic [16*NR-1:0] f;
    for (int i = 0; i < NR; i++) f[16*i +: 16] = mdl[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = 16'h0000;
  endtask

  // Drive one request at a negedge and hold it until accepted (bounded).
  task automatic send(input logic [39:0] d);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      errors++; checks++;
      $display("FAIL send_timeout: got tready=0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        word;
    logic [15:0] port;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vt[$];
  logic [15:0] e[4];
  logic [15:0] q[$];

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; r_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 256'(r_valid), 256'(0));
    chk("rst_tdata",  256'(r_data),  256'(0));
    chk("rst_regs",   256'(regs),    256'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_tready", 256'(s_ready), 256'(1));

    vt = '{
      '{0, 1, 16'h0080, 16'h0000, 16'h0000, "in_w_80_reset"},
      '{1, 1, 16'h0082, 16'hBEEF, 16'h0000, "out_w_82"},
      '{0, 1, 16'h0082, 16'h0000, 16'hBEEF, "in_w_82"},
      '{0, 1, 16'h0083, 16'h0000, 16'hBEEF, "in_w_83_align"},
      '{1, 1, 16'h0084, 16'h1234, 16'h0000, "out_w_84"},
      '{1, 0, 16'h0085, 16'h005A, 16'h0000, "out_b_85"},
      '{0, 1, 16'h0084, 16'h0000, 16'h5A34, "in_w_84"},
      '{0, 0, 16'h0084, 16'h0000, 16'h0034, "in_b_84"},
      '{0, 0, 16'h0085, 16'h0000, 16'h005A, "in_b_85"},
      '{0, 1, 16'h0090, 16'h0000, 16'hFFFF, "in_w_miss_90"},
      '{0, 0, 16'h007F, 16'h0000, 16'h00FF, "in_b_miss_7f"},
      '{1, 1, 16'h0090, 16'h1111, 16'h0000, "out_miss_90"},
      '{1, 0, 16'h0086, 16'hAB77, 16'h0000, "out_b_86"},
      '{0, 1, 16'h0086, 16'h0000, 16'h0077, "in_w_86"},
      '{1, 1, 16'h008E, 16'hC0DE, 16'h0000, "out_w_8e_last"},
      '{0, 0, 16'h008F, 16'h0000, 16'h00C0, "in_b_8f"},
      '{0, 1, 16'h007E, 16'h0000, 16'hFFFF, "in_w_miss_7e"}
    };
    foreach (vt[k]) begin
      logic [15:0] m;
      m = model_access(vt[k].wr, vt[k].word, vt[k].port, vt[k].wdata);
      send(mk(vt[k].wr, vt[k].word, vt[k].port, vt[k].wdata));
      @(negedge clk);
      if (vt[k].wr) begin
        chk({vt[k].name, "_noresp"}, 256'(r_valid), 256'(0));
      end else begin
        chk({vt[k].name, "_vld"}, 256'(r_valid), 256'(1));
        chk(vt[k].name, 256'(r_data), 256'(vt[k].exp));
      end
    end
    chk("regs_reg1_beef", 256'(regs[31:16]), 256'(16'hBEEF));
    chk("regs_after_table", 256'(regs), 256'(model_flat()));

    // Backpressure: four INs, response tready held low for 5 cycles.
    for (int k = 0; k < 4; k++) e[k] = model_access(0, 1, BASE + 16'(2 * (k + 1)), 16'h0);
    @(negedge clk);
    r_ready = 1'b0;
    s_valid = 1'b1; s_data = mk(0, 1, BASE + 16'd2, 16'h0);
    @(negedge clk);
    s_data = mk(0, 1, BASE + 16'd4, 16'h0);
    chk("bp_req_stalled", 256'(s_ready), 256'(0));
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_vld",  256'(r_valid), 256'(1));
      chk("bp_hold_data", 256'(r_data),  256'(e[0]));
      @(negedge clk);
    end
    r_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_stream_vld",  256'(r_valid), 256'(1));
      chk("bp_stream_data", 256'(r_data),  256'(e[k]));
      if (k < 3) s_data = mk(0, 1, BASE + 16'(2 * (k + 2)), 16'h0);
      else       s_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_drained", 256'(r_valid), 256'(0));

    // Reset while a response is held.
    r_ready = 1'b0;
    send(mk(0, 1, BASE + 16'd2, 16'h0));
    @(negedge clk);
    chk("rst_mid_pending", 256'(r_valid), 256'(1));
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 256'(r_valid), 256'(0));
    chk("rst_mid_regs",   256'(regs),    256'(0));
    model_reset();
    @(negedge clk);
    resetn = 1'b1; r_ready = 1'b1;
    send(mk(0, 1, BASE, 16'h0));
    @(negedge clk);
    chk("rst_mid_first_in_vld", 256'(r_valid), 256'(1));
    chk("rst_mid_first_in",     256'(r_data),  256'(16'h0000));

    // Random traffic against the model; the slot acts as a 1-deep queue.
    q.delete();
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        wr, word, acc, pop;
      logic [15:0] port, wd;
      wr   = 1'($urandom);
      word = 1'($urandom);
      port = 16'($urandom_range(16'h0070, 16'h00A0));
      wd   = 16'($urandom);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = mk(wr, word, port, wd);
      r_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_vld", 256'(r_valid), 256'(q.size() != 0));
      if (r_valid && q.size() != 0) chk("rnd_data", 256'(r_data), 256'(q[0]));
      pop = r_valid && r_ready;
      acc = s_valid && (q.size() == 0 || r_ready);
      if (pop && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        logic [15:0] m;
        m = model_access(wr, word, port, wd);
        if (!wr) q.push_back(m);
      end
      @(negedge clk);
    end
    s_valid = 1'b0; r_ready = 1'b1;
    @(negedge clk);
    chk("rnd_regs_final", 256'(regs), 256'(model_flat()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
